// File: rtl/fifo_ram_sync.sv
// Single-clock FIFO over a register array with a registered one-cycle read port.
// The status flags are decoded from the stored-word count; the overflow and underflow flags stay set until clr or rst.
module fifo_ram_sync #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2,
  parameter int AFULL_TH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 we,
  input  logic [WIDTH-1:0]     data_wr,
  input  logic                 re,
  output logic [WIDTH-1:0]     data_rd,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [DEPTH_LOG:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] AFULL_C = (DEPTH_LOG+1)'(AFULL_TH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic [WIDTH-1:0]     data_rd_q, data_rd_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 wr_ok, rd_ok;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AFULL_C);

  // clr wins over we/re, so neither the array nor any pointer moves in a flush cycle
  assign wr_ok = we && !full  && !clr;
  assign rd_ok = re && !empty && !clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_rd_d   = data_rd_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
      if (rd_ok) begin
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG'(1);
        data_rd_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + (DEPTH_LOG+1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LOG+1)'(1);
        default: count_d = count_q;
      endcase
      if (we && full)  overflow_d  = 1'b1;
      if (re && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_rd_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_rd_q   <= data_rd_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; stale words are never read because count gates rd_ok
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_wr;
  end

  assign data_rd   = data_rd_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ram_sync.sv
// Testbench for fifo_ram_sync: a queue-based reference model is compared with the DUT on every falling edge.
// Directed sequences with literal expectations cover the corner cases, and a randomized phase follows them.
module tb_fifo_ram_sync;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DEPTH_LOG = 2;
  localparam int AFULL_TH = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             we  = 1'b0;
  logic [WIDTH-1:0] data_wr = '0;
  logic             re  = 1'b0;
  logic [WIDTH-1:0] data_rd;
  logic             rd_valid, full, empty, almost_full, overflow, underflow;
  logic [DEPTH_LOG:0] count;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_data = '0;
  bit               m_valid = 1'b0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  fifo_ram_sync #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .data_wr(data_wr), .re(re),
    .data_rd(data_rd), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
    int n;
    n = m_q.size();
    if (c) begin
      m_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      if (r && n > 0) begin
        m_data  = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (w && n < DEPTH) m_q.push_back(d);
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_unf = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    chk("count",       32'(count),       32'(m_q.size()));
    chk("empty",       32'(empty),       32'(m_q.size() == 0));
    chk("full",        32'(full),        32'(m_q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(m_q.size() >= AFULL_TH));
    chk("rd_valid",    32'(rd_valid),    32'(m_valid));
    chk("data_rd",     32'(data_rd),     32'(m_data));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("underflow",   32'(underflow),   32'(m_unf));
  end

  task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
    we = w; data_wr = d; re = r; clr = c;
    @(posedge clk);
    model_step(w, d, r, c);
    #1;
  endtask

  // Reset asserted between edges; outputs are checked before any clock edge arrives
  task automatic rst_mid();
    we = 1'b0; re = 1'b0; clr = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_empty",    32'(empty),    32'h1);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_data_rd",  32'(data_rd),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("init_empty", 32'(empty), 32'h1);
    chk("init_count", 32'(count), 32'h0);

    // Fill to full, then drain in order
    cyc(1, 8'h11, 0, 0); chk("w1_count", 32'(count), 32'd1); chk("w1_af", 32'(almost_full), 32'h0);
    cyc(1, 8'h22, 0, 0); chk("w2_count", 32'(count), 32'd2); chk("w2_af", 32'(almost_full), 32'h0);
    cyc(1, 8'h33, 0, 0); chk("w3_count", 32'(count), 32'd3); chk("w3_af", 32'(almost_full), 32'h1);
    chk("w3_full", 32'(full), 32'h0);
    cyc(1, 8'h44, 0, 0); chk("w4_count", 32'(count), 32'd4); chk("w4_full", 32'(full), 32'h1);
    chk("model_full_size", 32'(m_q.size()), 32'd4);

    cyc(1, 8'h55, 0, 0); chk("ovf_count", 32'(count), 32'd4); chk("ovf_flag", 32'(overflow), 32'h1);
    cyc(0, 8'h00, 1, 0); chk("r1_data", 32'(data_rd), 32'h11); chk("r1_valid", 32'(rd_valid), 32'h1);
    cyc(0, 8'h00, 1, 0); chk("r2_data", 32'(data_rd), 32'h22);
    cyc(0, 8'h00, 1, 0); chk("r3_data", 32'(data_rd), 32'h33);
    cyc(0, 8'h00, 1, 0); chk("r4_data", 32'(data_rd), 32'h44); chk("r4_empty", 32'(empty), 32'h1);
    cyc(0, 8'h00, 0, 0); chk("idle_valid", 32'(rd_valid), 32'h0); chk("idle_hold", 32'(data_rd), 32'h44);

    // Empty with simultaneous write and read: the write is accepted and the read is rejected
    cyc(1, 8'hA0, 1, 0); chk("e_count", 32'(count), 32'd1); chk("e_valid", 32'(rd_valid), 32'h0);
    chk("e_unf", 32'(underflow), 32'h1);
    cyc(0, 8'h00, 1, 0); chk("e_data", 32'(data_rd), 32'hA0);

    // Steady occupancy of 2 while pointers wrap
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 8'(k + 3), 1, 0);
      chk("wrap_count", 32'(count), 32'd2);
      chk("wrap_data", 32'(data_rd), 32'(k + 1));
    end

    // clr with an outstanding write request discards that write
    cyc(1, 8'h09, 0, 0); chk("pre_clr_count", 32'(count), 32'd3); chk("pre_clr_ovf", 32'(overflow), 32'h1);
    cyc(1, 8'hEE, 0, 1); chk("clr_count", 32'(count), 32'd0); chk("clr_empty", 32'(empty), 32'h1);
    chk("clr_ovf", 32'(overflow), 32'h0);
    cyc(1, 8'h5A, 0, 0); chk("post_clr_count", 32'(count), 32'd1);
    cyc(0, 8'h00, 1, 0); chk("post_clr_data", 32'(data_rd), 32'h5A);

    // Asynchronous reset with three words stored
    cyc(1, 8'hC1, 0, 0);
    cyc(1, 8'hC2, 0, 0);
    cyc(1, 8'hC3, 0, 0); chk("pre_rst_count", 32'(count), 32'd3);
    rst_mid();
    cyc(1, 8'h77, 0, 0); chk("post_rst_count", 32'(count), 32'd1);
    cyc(0, 8'h00, 1, 0); chk("post_rst_data", 32'(data_rd), 32'h77);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
          $urandom_range(0, 39) == 0);
    end
    rst_mid();
    repeat (20) cyc(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)), 1'b0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ram_sync.md
FIFO_RAM_SYNC -- requirements
Module: fifo_ram_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage words; power of two, >= 2.
REQ-003 SHALL have parameter DEPTH_LOG, default 2, log2(DEPTH).
REQ-004 SHALL have parameter AFULL_TH, default 3, almost_full threshold in words, 1..DEPTH.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port clr  input  1  synchronous flush.
REQ-008 SHALL have port we  input  1  write request.
REQ-009 SHALL have port data_wr  input  WIDTH  write data.
REQ-010 SHALL have port re  input  1  read request.
REQ-011 SHALL have port data_rd  output  WIDTH  registered read data.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse; data_rd holds a newly popped word.
REQ-013 SHALL have port full  output  1  count == DEPTH.
REQ-014 SHALL have port empty  output  1  count == 0.
REQ-015 SHALL have port almost_full  output  1  count >= AFULL_TH.
REQ-016 SHALL have port count  output  DEPTH_LOG+1  words stored, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  sticky; a write was rejected.
REQ-018 SHALL have port underflow  output  1  sticky; a read was rejected.

Function
REQ-019 SHALL store words in an internal DEPTH x WIDTH register array addressed by DEPTH_LOG-bit write and read pointers.
REQ-020 SHALL accept a write (wr_ok) when we=1 and full=0: data_wr is written at wr_ptr, wr_ptr increments.
REQ-021 SHALL accept a read (rd_ok) when re=1 and empty=0: word at rd_ptr is loaded into data_rd, rd_ptr increments, rd_valid=1 next cycle.
REQ-022 SHALL use a read latency of exactly one cycle: data_rd and rd_valid update on the edge that samples re.
REQ-023 SHALL hold data_rd unchanged when no read is accepted; rd_valid=0 in that cycle.
REQ-024 SHALL wrap pointers from DEPTH-1 to 0 by natural modulo-DEPTH overflow.
REQ-025 SHALL update count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-026 SHALL reject writes when full, even if re=1 the same cycle (no write-through on full); the read is still accepted.
REQ-027 SHALL reject reads when empty, even if we=1 the same cycle (no fall-through); the write is still accepted.
REQ-028 SHALL set overflow on we=1 with full=1; set underflow on re=1 with empty=1; both hold until clr or rst.
REQ-029 SHALL on clr=1 zero pointers, count, rd_valid, overflow, underflow; clr overrides we/re that cycle; data_rd and array contents are unchanged.
REQ-030 SHALL derive full, empty and almost_full combinationally from count only.

Reset
REQ-031 SHALL on rst=1, without waiting for clk, drive pointers=0, count=0, data_rd=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_full=0.
REQ-032 SHALL leave array contents unreset; they are unreadable until rewritten.
REQ-033 SHALL when rst asserts mid-operation abandon all stored words and a pending read result.
REQ-034 SHALL resume accepting we/re on the first rising clk edge after rst deasserts.

Verification (WIDTH=8, DEPTH=4, AFULL_TH=3)
REQ-035 SHALL cover: write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full after 4th; then 4 reads -> data_rd 0x11..0x44 each 1 cycle after re, rd_valid pulses, empty at end.
REQ-036 SHALL cover: full, we=1 data 0x55 -> count stays 4, overflow=1; subsequent reads never return 0x55.
REQ-037 SHALL cover: empty, we=1 0xA0 and re=1 same cycle -> count 1, rd_valid=0, underflow=1; next read returns 0xA0.
REQ-038 SHALL cover: count 2, we=1 and re=1 for 6 cycles -> count stays 2, pointers wrap, FIFO order preserved.
REQ-039 SHALL cover: count 3, overflow=1, clr=1 with we=1 -> count 0, empty=1, overflow=0, write discarded.
REQ-040 SHALL cover: rst pulsed between clk edges with count 3 -> count 0, empty=1 immediately; rd_valid=0, data_rd=0x00.
